serv_irq_csr: RTL and testbench

//  Bit-serial machine-mode CSR/interrupt unit for the SERV core: mstatus(MIE,MPIE), mie, mip, mcause.

---
 rtl/serv_irq_csr_if.sv | 52 +++++
 rtl/serv_irq_csr.sv | 176 +++++++++++++++++
 tb/tb_serv_irq_csr.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_irq_csr_if.sv
// Serial CSR/interrupt bus between the SERV control path (master) and the
// machine-mode CSR/interrupt unit (slave).
interface serv_irq_csr_if #(
  parameter int N_LOCAL = 4
);
  localparam int LW = (N_LOCAL > 0) ? N_LOCAL : 1;

  logic          i_init;
  logic          i_en;
  logic [4:0]    i_cnt;
  logic          i_cnt_done;
  logic          i_trap;
  logic          i_mret;
  logic          i_mstatus_en;
  logic          i_mie_en;
  logic          i_mip_en;
  logic          i_mcause_en;
  logic [1:0]    i_csr_source;
  logic          i_csr_d_sel;
  logic          i_csr_imm;
  logic          i_rs1;
  logic          i_rf_csr_out;
  logic          i_e_op;
  logic          i_ebreak;
  logic          i_mem_op;
  logic          i_mem_cmd;
  logic          i_msip;
  logic          i_mtip;
  logic          i_meip;
  logic [LW-1:0] i_lirq;
  logic          o_irq;
  logic          o_csr_in;
  logic          o_q;

  modport master (
    output i_init, i_en, i_cnt, i_cnt_done, i_trap, i_mret,
           i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en,
           i_csr_source, i_csr_d_sel, i_csr_imm, i_rs1, i_rf_csr_out,
           i_e_op, i_ebreak, i_mem_op, i_mem_cmd,
           i_msip, i_mtip, i_meip, i_lirq,
    input  o_irq, o_csr_in, o_q
  );

  modport slave (
    input  i_init, i_en, i_cnt, i_cnt_done, i_trap, i_mret,
           i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en,
           i_csr_source, i_csr_d_sel, i_csr_imm, i_rs1, i_rf_csr_out,
           i_e_op, i_ebreak, i_mem_op, i_mem_cmd,
           i_msip, i_mtip, i_meip, i_lirq,
    output o_irq, o_csr_in, o_q
  );
endinterface

// File: rtl/serv_irq_csr.sv
// Bit-serial machine-mode CSR and interrupt unit: mstatus (MIE/MPIE), mie,
// mip, mcause. One CSR bit per cycle, LSB first, bit index on i_cnt.
module serv_irq_csr #(
  parameter int    N_LOCAL        = 4,
  parameter int    SYNC_STAGES    = 2,
  parameter string RESET_STRATEGY = "MINI"
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  serv_irq_csr_if.slave bus
);
  localparam int LW         = (N_LOCAL > 0) ? N_LOCAL : 1;
  localparam int SW         = LW + 1;
  localparam bit RESET_MINI = (RESET_STRATEGY == "MINI");

  typedef struct packed {
    logic          mstatus_mie;
    logic          mstatus_mpie;
    logic          msie;
    logic          mtie;
    logic          meie;
    logic [LW-1:0] lie;
    logic          mcause_int;
    logic [4:0]    mcause_code;
    logic [4:0]    irq_code;
  } csr_state_t;

  csr_state_t  csr_q, csr_d;
  logic        irq_q, irq_d;
  logic [SW-1:0] async_lvl, sync_lvl;
  logic [31:0] mstatus_v, mie_v, mip_v, mcause_v, pend;
  logic        csr_bit, d_bit, csr_in;
  logic [4:0]  win_code, exc_code;
  logic        boundary, trap_now, mret_now;

  assign async_lvl = {bus.i_lirq, bus.i_meip};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_lvl = async_lvl;
    end else begin : g_sync
      logic [SW-1:0] sync_q [SYNC_STAGES];
      // Shift external/local IRQ levels through the synchroniser chain
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          // NOTE: non-blocking so every stage samples the previous stage's old value.
          sync_q[0] <= async_lvl;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign sync_lvl = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Assemble 32-bit architectural views of each CSR; unimplemented bits are 0
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    mstatus_v     = '0;
    mstatus_v[3]  = csr_q.mstatus_mie;
    mstatus_v[7]  = csr_q.mstatus_mpie;
    mie_v         = '0;
    mie_v[3]      = csr_q.msie;
    mie_v[7]      = csr_q.mtie;
    mie_v[11]     = csr_q.meie;
    mip_v         = '0;
    mip_v[3]      = bus.i_msip;
    mip_v[7]      = bus.i_mtip;
    mip_v[11]     = sync_lvl[0];
    for (int k = 0; k < N_LOCAL; k++) begin
      mie_v[16+k] = csr_q.lie[k];
      mip_v[16+k] = sync_lvl[1+k];
    end
    mcause_v      = {csr_q.mcause_int, 26'd0, csr_q.mcause_code};
  end

  assign csr_bit = (bus.i_mstatus_en & mstatus_v[bus.i_cnt])
                 | (bus.i_mie_en     & mie_v[bus.i_cnt])
                 | (bus.i_mip_en     & mip_v[bus.i_cnt])
                 | (bus.i_mcause_en  & mcause_v[bus.i_cnt]);

  assign bus.o_q = bus.i_rf_csr_out | (bus.i_en & csr_bit);
  assign d_bit   = bus.i_csr_d_sel ? bus.i_csr_imm : bus.i_rs1;

  // Serial write data: plain write, set, clear, or pass the current value
  always_comb begin
    csr_in = bus.o_q;
    case (bus.i_csr_source)
      2'b01:   csr_in = d_bit;
      2'b10:   csr_in = bus.o_q | d_bit;
      2'b11:   csr_in = bus.o_q & ~d_bit;
      default: csr_in = bus.o_q;
    endcase
  end
  assign bus.o_csr_in = csr_in;

  assign pend = mip_v & mie_v;

  // Priority encode pending IRQs: MEI > MSI > MTI > local (highest k wins)
  always_comb begin
    win_code = 5'd0;
    for (int k = 0; k < N_LOCAL; k++) begin
      if (pend[16+k]) win_code = 5'(16 + k);
    end
    if (pend[7])  win_code = 5'd7;
    if (pend[3])  win_code = 5'd3;
    if (pend[11]) win_code = 5'd11;
  end

  assign exc_code = bus.i_e_op   ? (bus.i_ebreak  ? 5'd3 : 5'd11) :
                    bus.i_mem_op ? (bus.i_mem_cmd ? 5'd6 : 5'd4)  : 5'd0;

  assign boundary = !bus.i_init & bus.i_cnt_done;
  assign trap_now = bus.i_trap & bus.i_cnt_done;
  assign mret_now = bus.i_mret & bus.i_cnt_done;

  // Next CSR state: serial writes first, then mret, then trap (trap wins)
  always_comb begin
    csr_d = csr_q;
    irq_d = irq_q;
    if (bus.i_en & bus.i_mstatus_en) begin
      if (bus.i_cnt == 5'd3) csr_d.mstatus_mie  = csr_in;
      if (bus.i_cnt == 5'd7) csr_d.mstatus_mpie = csr_in;
    end
    if (bus.i_en & bus.i_mie_en) begin
      if (bus.i_cnt == 5'd3)  csr_d.msie = csr_in;
      if (bus.i_cnt == 5'd7)  csr_d.mtie = csr_in;
      if (bus.i_cnt == 5'd11) csr_d.meie = csr_in;
      for (int k = 0; k < N_LOCAL; k++) begin
        if (bus.i_cnt == 5'(16 + k)) csr_d.lie[k] = csr_in;
      end
    end
    if (bus.i_en & bus.i_mcause_en) begin
      if (bus.i_cnt < 5'd5)   csr_d.mcause_code[bus.i_cnt[2:0]] = csr_in;
      if (bus.i_cnt == 5'd31) csr_d.mcause_int = csr_in;
    end
    if (boundary) begin
      irq_d          = csr_q.mstatus_mie & (|pend);
      csr_d.irq_code = win_code;
    end
    if (mret_now) begin
      csr_d.mstatus_mie  = csr_q.mstatus_mpie;
      csr_d.mstatus_mpie = 1'b1;
    end
    if (trap_now) begin
      csr_d.mstatus_mpie = csr_q.mstatus_mie;
      csr_d.mstatus_mie  = 1'b0;
      csr_d.mcause_int   = irq_q;
      csr_d.mcause_code  = irq_q ? csr_q.irq_code : exc_code;
    end
  end

  generate
    if (RESET_MINI) begin : g_rst_mini
      // CSR state register with reset
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) csr_q <= '0;
        else          csr_q <= csr_d;
      end
    end else begin : g_rst_none
      // NOTE: left unreset on purpose; software initialises these CSRs before enabling IRQs.
      always_ff @(posedge i_clk) begin
        csr_q <= csr_d;
      end
    end
  endgenerate

  // Interrupt request register, always reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign bus.o_irq = irq_q;
endmodule

// File: tb/tb_serv_irq_csr.sv
// Self-checking bench for serv_irq_csr: directed table, priority and sync
// sequences, mid-instruction reset, and random instructions vs a word-level model.
module tb_serv_irq_csr;
  typedef enum int {S_NONE, S_MSTATUS, S_MIE, S_MIP, S_MCAUSE} sel_e;
  typedef enum int {K_NONE, K_TRAP, K_ECALL, K_EBREAK, K_LOAD, K_STORE, K_MRET} kind_e;
  typedef struct {
    sel_e        sel;
    logic [1:0]  src;
    logic [31:0] d;
    bit          imm;
    kind_e       kind;
    bit          init;
  } instr_t;
  typedef struct {
    instr_t      ins;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  localparam logic [1:0]  SRC_CSR  = 2'b00;
  localparam logic [1:0]  SRC_WR   = 2'b01;
  localparam logic [1:0]  SRC_SET  = 2'b10;
  localparam logic [1:0]  SRC_CLR  = 2'b11;
  localparam logic [31:0] MIE_MASK = 32'h000F_0888;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  // word-level reference state
  logic [31:0] m_mstatus, m_mie, m_mcause;
  logic        m_irq;
  logic [4:0]  m_code;

  serv_irq_csr_if #(.N_LOCAL(4)) bus ();

  serv_irq_csr #(
    .N_LOCAL(4), .SYNC_STAGES(2), .RESET_STRATEGY("MINI")
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(sel_e sel, logic [1:0] src, logic [31:0] d, bit imm,
                                kind_e kind, bit init = 1'b0);
    instr_t t;
    t.sel = sel; t.src = src; t.d = d; t.imm = imm; t.kind = kind; t.init = init;
    return t;
  endfunction

  function automatic vec_t mkv(sel_e sel, logic [1:0] src, logic [31:0] d, bit imm,
                               kind_e kind, logic [31:0] rd, logic irq);
    vec_t v;
    v.ins = mk(sel, src, d, imm, kind);
    v.exp_rd = rd; v.exp_irq = irq;
    return v;
  endfunction

  function automatic bit is_trap(kind_e k);
    return (k == K_TRAP) || (k == K_ECALL) || (k == K_EBREAK) || (k == K_LOAD) || (k == K_STORE);
  endfunction

  function automatic logic [31:0] exc_of(kind_e k);
    case (k)
      K_ECALL:  return 32'd11;
      K_EBREAK: return 32'd3;
      K_LOAD:   return 32'd4;
      K_STORE:  return 32'd6;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mip_word();
    logic [31:0] w;
    w = '0;
    w[3] = bus.i_msip; w[7] = bus.i_mtip; w[11] = bus.i_meip; w[19:16] = bus.i_lirq;
    return w;
  endfunction

  function automatic logic [4:0] prio(logic [31:0] p);
    if (p[11]) return 5'd11;
    if (p[3])  return 5'd3;
    if (p[7])  return 5'd7;
    for (int k = 3; k >= 0; k--) if (p[16+k]) return 5'(16 + k);
    return 5'd0;
  endfunction

  // Whole-instruction effect computed on full CSR words
  task automatic model_step(input instr_t t, output logic [31:0] rd);
    logic [31:0] old, nw, p;
    logic        irq_n;
    logic [4:0]  code_n;
    case (t.sel)
      S_MSTATUS: old = m_mstatus;
      S_MIE:     old = m_mie;
      S_MIP:     old = mip_word();
      S_MCAUSE:  old = m_mcause;
      default:   old = '0;
    endcase
    rd = old;
    case (t.src)
      SRC_WR:  nw = t.d;
      SRC_SET: nw = old | t.d;
      SRC_CLR: nw = old & ~t.d;
      default: nw = old;
    endcase
    case (t.sel)
      S_MSTATUS: m_mstatus = nw & 32'h0000_0088;
      S_MIE:     m_mie     = nw & MIE_MASK;
      S_MCAUSE:  m_mcause  = nw & 32'h8000_001F;
      default: ;
    endcase
    p = mip_word() & m_mie;
    irq_n = m_irq; code_n = m_code;
    if (!t.init) begin
      irq_n  = m_mstatus[3] && (p != 0);
      code_n = prio(p);
    end
    if (t.kind == K_MRET) m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    if (is_trap(t.kind)) begin
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      m_mcause  = m_irq ? (32'h8000_0000 | {27'd0, m_code}) : exc_of(t.kind);
    end
    m_irq = irq_n; m_code = code_n;
  endtask

  task automatic model_reset();
    m_mstatus = '0; m_mie = '0; m_mcause = '0; m_irq = 1'b0; m_code = '0;
  endtask

  task automatic clear_inputs();
    bus.i_init = 0; bus.i_en = 0; bus.i_cnt = '0; bus.i_cnt_done = 0;
    bus.i_trap = 0; bus.i_mret = 0;
    bus.i_mstatus_en = 0; bus.i_mie_en = 0; bus.i_mip_en = 0; bus.i_mcause_en = 0;
    bus.i_csr_source = '0; bus.i_csr_d_sel = 0; bus.i_csr_imm = 0; bus.i_rs1 = 0;
    bus.i_rf_csr_out = 0; bus.i_e_op = 0; bus.i_ebreak = 0; bus.i_mem_op = 0; bus.i_mem_cmd = 0;
  endtask

  task automatic set_levels(input logic msip, input logic mtip, input logic meip,
                            input logic [3:0] lirq);
    bus.i_msip = msip; bus.i_mtip = mtip; bus.i_meip = meip; bus.i_lirq = lirq;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input instr_t t, input int c);
    bus.i_en         = 1'b1;
    bus.i_cnt        = 5'(c);
    bus.i_cnt_done   = (c == 31);
    bus.i_init       = t.init;
    bus.i_mstatus_en = (t.sel == S_MSTATUS);
    bus.i_mie_en     = (t.sel == S_MIE);
    bus.i_mip_en     = (t.sel == S_MIP);
    bus.i_mcause_en  = (t.sel == S_MCAUSE);
    bus.i_csr_source = t.src;
    bus.i_csr_d_sel  = t.imm;
    bus.i_csr_imm    = t.imm ? t.d[c] : ~t.d[c];
    bus.i_rs1        = t.imm ? ~t.d[c] : t.d[c];
    bus.i_trap       = is_trap(t.kind);
    bus.i_mret       = (t.kind == K_MRET);
    bus.i_e_op       = (t.kind == K_ECALL) || (t.kind == K_EBREAK);
    bus.i_ebreak     = (t.kind == K_EBREAK);
    bus.i_mem_op     = (t.kind == K_LOAD) || (t.kind == K_STORE);
    bus.i_mem_cmd    = (t.kind == K_STORE);
  endtask

  task automatic run_instr(input instr_t t, output logic [31:0] rd_dut,
                           output logic [31:0] rd_mod);
    rd_dut = '0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      drive_bit(t, c);
      #1 rd_dut[c] = bus.o_q;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    model_step(t, rd_mod);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, rdm;
    logic [31:0] pr_mask[4];
    logic [31:0] pr_code[4];
    logic [31:0] pats[4];
    instr_t      t;

    rst_n = 1'b0;
    clear_inputs();
    set_levels(0, 0, 0, 4'h0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    #1 check("reset_irq", {31'd0, bus.o_irq}, 32'd0);

    // ---- directed table (mtip is the only active level) ----
    set_levels(0, 1, 0, 4'h0);
    idle(4);
    tbl.push_back(mkv(S_MIE,     SRC_SET, 32'h888,       1, K_NONE,   32'h0,        0));
    tbl.push_back(mkv(S_MSTATUS, SRC_SET, 32'h8,         0, K_NONE,   32'h0,        1));
    tbl.push_back(mkv(S_MIE,     SRC_CSR, 32'h0,         0, K_NONE,   32'h888,      1));
    tbl.push_back(mkv(S_NONE,    SRC_CSR, 32'h0,         0, K_TRAP,   32'h0,        1));
    tbl.push_back(mkv(S_MCAUSE,  SRC_CSR, 32'h0,         0, K_NONE,   32'h80000007, 0));
    tbl.push_back(mkv(S_MSTATUS, SRC_CSR, 32'h0,         0, K_NONE,   32'h80,       0));
    tbl.push_back(mkv(S_NONE,    SRC_CSR, 32'h0,         0, K_MRET,   32'h0,        0));
    tbl.push_back(mkv(S_MSTATUS, SRC_CSR, 32'h0,         0, K_NONE,   32'h88,       1));
    tbl.push_back(mkv(S_MSTATUS, SRC_CLR, 32'h8,         1, K_NONE,   32'h88,       0));
    tbl.push_back(mkv(S_NONE,    SRC_CSR, 32'h0,         0, K_ECALL,  32'h0,        0));
    tbl.push_back(mkv(S_MCAUSE,  SRC_CSR, 32'h0,         0, K_NONE,   32'hB,        0));
    tbl.push_back(mkv(S_NONE,    SRC_CSR, 32'h0,         0, K_STORE,  32'h0,        0));
    tbl.push_back(mkv(S_MCAUSE,  SRC_CSR, 32'h0,         0, K_NONE,   32'h6,        0));
    tbl.push_back(mkv(S_NONE,    SRC_CSR, 32'h0,         0, K_EBREAK, 32'h0,        0));
    tbl.push_back(mkv(S_MCAUSE,  SRC_CSR, 32'h0,         0, K_NONE,   32'h3,        0));
    tbl.push_back(mkv(S_NONE,    SRC_CSR, 32'h0,         0, K_LOAD,   32'h0,        0));
    tbl.push_back(mkv(S_MCAUSE,  SRC_CSR, 32'h0,         0, K_NONE,   32'h4,        0));
    tbl.push_back(mkv(S_NONE,    SRC_CSR, 32'h0,         0, K_TRAP,   32'h0,        0));
    tbl.push_back(mkv(S_MCAUSE,  SRC_CSR, 32'h0,         0, K_NONE,   32'h0,        0));
    tbl.push_back(mkv(S_MIP,     SRC_WR,  32'hFFFFFFFF,  1, K_NONE,   32'h80,       0));
    tbl.push_back(mkv(S_MIP,     SRC_CSR, 32'h0,         0, K_NONE,   32'h80,       0));
    tbl.push_back(mkv(S_MCAUSE,  SRC_WR,  32'hFFFFFFFF,  0, K_NONE,   32'h0,        0));
    tbl.push_back(mkv(S_MCAUSE,  SRC_CSR, 32'h0,         0, K_NONE,   32'h8000001F, 0));
    tbl.push_back(mkv(S_MSTATUS, SRC_WR,  32'hFFFFFFFF,  1, K_NONE,   32'h0,        1));
    tbl.push_back(mkv(S_MSTATUS, SRC_CSR, 32'h0,         0, K_NONE,   32'h88,       1));
    tbl.push_back(mkv(S_MSTATUS, SRC_CLR, 32'hFFFFFFFF,  0, K_NONE,   32'h88,       0));
    tbl.push_back(mkv(S_MIE,     SRC_CLR, 32'hFFFFFFFF,  1, K_NONE,   32'h888,      0));
    tbl.push_back(mkv(S_MIE,     SRC_CSR, 32'h0,         0, K_NONE,   32'h0,        0));
    tbl.push_back(mkv(S_MIE,     SRC_WR,  32'hFFFFFFFF,  0, K_NONE,   32'h0,        0));
    tbl.push_back(mkv(S_MIE,     SRC_CSR, 32'h0,         0, K_NONE,   MIE_MASK,     0));
    foreach (tbl[i]) begin
      run_instr(tbl[i].ins, rd, rdm);
      check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_irq", i), {31'd0, bus.o_irq}, {31'd0, tbl[i].exp_irq});
    end

    // ---- priority: peel off the winner one enable at a time ----
    pr_mask = '{32'h0, 32'h800, 32'h8, 32'h80};
    pr_code = '{32'd11, 32'd3, 32'd7, 32'd18};
    set_levels(1, 1, 1, 4'b0100);
    idle(4);
    for (int s = 0; s < 4; s++) begin
      run_instr(mk(S_MIE, SRC_CLR, pr_mask[s], 0, K_NONE), rd, rdm);
      run_instr(mk(S_MSTATUS, SRC_SET, 32'h8, 1, K_NONE), rd, rdm);
      check($sformatf("prio%0d_irq", s), {31'd0, bus.o_irq}, 32'd1);
      run_instr(mk(S_NONE, SRC_CSR, 32'h0, 0, K_TRAP), rd, rdm);
      run_instr(mk(S_MCAUSE, SRC_CSR, 32'h0, 0, K_NONE), rd, rdm);
      check($sformatf("prio%0d_mcause", s), rd, 32'h8000_0000 | pr_code[s]);
    end

    // ---- meip synchroniser latency, rf OR-in, and i_en gating ----
    set_levels(0, 0, 0, 4'h0);
    idle(4);
    @(negedge clk);
    bus.i_en = 1; bus.i_mip_en = 1; bus.i_cnt = 5'd11;
    #1 check("sync_pre", {31'd0, bus.o_q}, 32'd0);
    bus.i_meip = 1'b1;
    @(negedge clk);
    #1 check("sync_1clk", {31'd0, bus.o_q}, 32'd0);
    @(negedge clk);
    #1 check("sync_2clk", {31'd0, bus.o_q}, 32'd1);
    bus.i_en = 0; bus.i_rf_csr_out = 1;
    #1 check("rf_or", {31'd0, bus.o_q}, 32'd1);
    bus.i_rf_csr_out = 0;
    #1 check("en_gate", {31'd0, bus.o_q}, 32'd0);
    clear_inputs();

    // ---- reset in the middle of an instruction ----
    set_levels(0, 1, 0, 4'h0);
    idle(4);
    run_instr(mk(S_MIE, SRC_WR, 32'h80, 0, K_NONE), rd, rdm);
    run_instr(mk(S_MSTATUS, SRC_SET, 32'h8, 0, K_NONE), rd, rdm);
    check("pre_rst_irq", {31'd0, bus.o_irq}, 32'd1);
    t = mk(S_MIE, SRC_WR, 32'hFFFFFFFF, 0, K_NONE);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      drive_bit(t, c);
      #1;
    end
    rst_n = 1'b0;
    #1 check("rst_mid_irq", {31'd0, bus.o_irq}, 32'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    model_reset();
    run_instr(mk(S_MIE, SRC_CSR, 32'h0, 0, K_NONE), rd, rdm);
    check("rst_mie", rd, 32'h0);
    run_instr(mk(S_MSTATUS, SRC_CSR, 32'h0, 0, K_NONE), rd, rdm);
    check("rst_mstatus", rd, 32'h0);
    run_instr(mk(S_MCAUSE, SRC_CSR, 32'h0, 0, K_NONE), rd, rdm);
    check("rst_mcause", rd, 32'h0);
    check("rst_irq_after", {31'd0, bus.o_irq}, 32'd0);

    // ---- random instructions against the word-level model ----
    pats = '{32'hFFFFFFFF, 32'h00000888, 32'h000F0008, 32'h8000001F};
    for (int n = 0; n < 100; n++) begin
      int kr;
      if ($urandom_range(0, 3) == 0) begin
        set_levels(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 4'($urandom));
        idle(3);
      end
      t.sel  = sel_e'($urandom_range(0, 4));
      t.src  = 2'($urandom_range(0, 3));
      t.d    = $urandom & pats[$urandom_range(0, 3)];
      t.imm  = 1'($urandom_range(0, 1));
      t.init = ($urandom_range(0, 7) == 0);
      kr = $urandom_range(0, 11);
      case (kr)
        7:       t.kind = K_MRET;
        8:       t.kind = K_TRAP;
        9:       t.kind = $urandom_range(0, 1) ? K_ECALL : K_EBREAK;
        10:      t.kind = $urandom_range(0, 1) ? K_LOAD : K_STORE;
        default: t.kind = K_NONE;
      endcase
      run_instr(t, rd, rdm);
      check($sformatf("rnd%0d_rd", n), rd, rdm);
      check($sformatf("rnd%0d_irq", n), {31'd0, bus.o_irq}, {31'd0, m_irq});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
